// File: rtl/spi_master_mc_if.sv
// spi_master_mc_if: CPU strobe/data bus and SPI pin bundle for spi_master_mc
interface spi_master_mc_if #(parameter int NUM_CS = 2);
  logic data_wr, data_rd, cs_wr, ctl_wr, stat_rd;
  logic [7:0] d_in, d_out;
  logic d_out_active, cpuwait;
  logic sd_miso, sd_mosi, sd_sck;
  logic [NUM_CS-1:0] sd_cs;
  modport master (
    output data_wr, data_rd, cs_wr, ctl_wr, stat_rd, d_in, sd_miso,
    input  d_out, d_out_active, cpuwait, sd_mosi, sd_sck, sd_cs
  );
  modport slave (
    input  data_wr, data_rd, cs_wr, ctl_wr, stat_rd, d_in, sd_miso,
    output d_out, d_out_active, cpuwait, sd_mosi, sd_sck, sd_cs
  );
endinterface

// File: rtl/spi_master_mc.sv
// spi_master_mc: mode-0 SPI master with chip selects and programmable SCK divider
// Define SPI_HOLD_BUF_EN to add a one-byte transmit holding buffer.
module spi_master_mc #(
  parameter int NUM_CS = 2,
  parameter int DIV_W = 4,
  parameter int DIV_RST = 1,
  parameter logic [7:0] IDLE_TX = 8'hFF
) (
  input logic clk28,
  input logic rst_n,
  spi_master_mc_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
`ifdef SPI_HOLD_BUF_EN
  localparam bit HOLD_EN = 1'b1;
  logic [7:0] hold_q;
  logic hold_full_q;
  logic hf;
  assign hf = hold_full_q;
`else
  localparam bit HOLD_EN = 1'b0;
  logic hf;
  assign hf = 1'b0;
`endif
  state_t state_q;
  logic [7:0] shift_q, rx_shift_q, rx_q, dout_q, start_byte;
  logic [2:0] bit_q;
  logic [DIV_W-1:0] cnt_q, div_q, div_d;
  logic [NUM_CS-1:0] cs_q;
  logic sck_q, mosi_q, wait_q, act_q, ovr_q;
  logic wr, rd, csw, ctw, st, start, busy_wr;
  assign wr = bus.data_wr;
  assign rd = bus.data_rd & ~wr;
  assign csw = bus.cs_wr & ~wr & ~rd;
  assign ctw = bus.ctl_wr & ~wr & ~rd & ~bus.cs_wr;
  assign st = bus.stat_rd & ~wr & ~rd & ~bus.cs_wr & ~bus.ctl_wr;
  assign div_d = ctw ? bus.d_in[DIV_W-1:0] : div_q;
  // A write landing on DONE with an empty buffer chains straight into the next byte
  assign start = (state_q == IDLE && (wr || rd)) || (HOLD_EN && wr && state_q == DONE && !hf);
  assign busy_wr = wr && !start;
  assign start_byte = wr ? bus.d_in : IDLE_TX;
  assign bus.d_out = dout_q;
  assign bus.d_out_active = act_q;
  assign bus.cpuwait = wait_q;
  assign bus.sd_mosi = mosi_q;
  assign bus.sd_sck = sck_q;
  assign bus.sd_cs = cs_q;
  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= 8'h00;
      rx_shift_q <= 8'h00;
      rx_q <= 8'h00;
      dout_q <= 8'h00;
      bit_q <= 3'd0;
      cnt_q <= '0;
      div_q <= DIV_W'(DIV_RST);
      cs_q <= '1;
      sck_q <= 1'b0;
      mosi_q <= 1'b1;
      wait_q <= 1'b0;
      act_q <= 1'b0;
      ovr_q <= 1'b0;
`ifdef SPI_HOLD_BUF_EN
      hold_q <= 8'h00;
      hold_full_q <= 1'b0;
`endif
    end else begin
      div_q <= div_d;
      if (csw) cs_q <= bus.d_in[NUM_CS-1:0];
      act_q <= rd | st;
      dout_q <= rd ? rx_q : st ? {wait_q, hf, ovr_q, 5'b0} : 8'h00;
      if (st) ovr_q <= 1'b0;
`ifdef SPI_HOLD_BUF_EN
      if (busy_wr && hold_full_q) ovr_q <= 1'b1;
      if (busy_wr && !hold_full_q) begin
        hold_q <= bus.d_in;
        hold_full_q <= 1'b1;
      end
`else
      if (busy_wr) ovr_q <= 1'b1;
`endif
      if (state_q == DONE) rx_q <= rx_shift_q;
      if (start) begin
        state_q <= LOW;
        shift_q <= start_byte;
        bit_q <= 3'd7;
        cnt_q <= div_d;
        sck_q <= 1'b0;
        mosi_q <= start_byte[7];
        wait_q <= 1'b1;
      end else begin
        case (state_q)
          LOW:
            if (cnt_q == '0) begin
              state_q <= HIGH;
              sck_q <= 1'b1;
              cnt_q <= div_d;
              rx_shift_q <= {rx_shift_q[6:0], bus.sd_miso};
            end else cnt_q <= cnt_q - 1'b1;
          HIGH:
            if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
            else if (bit_q != 3'd0) begin
              state_q <= LOW;
              sck_q <= 1'b0;
              shift_q <= {shift_q[6:0], 1'b0};
              mosi_q <= shift_q[6];
              bit_q <= bit_q - 3'd1;
              cnt_q <= div_d;
            end else begin
              state_q <= DONE;
              sck_q <= 1'b0;
              mosi_q <= 1'b1;
            end
          DONE: begin
`ifdef SPI_HOLD_BUF_EN
            if (hold_full_q) begin
              state_q <= LOW;
              shift_q <= hold_q;
              mosi_q <= hold_q[7];
              bit_q <= 3'd7;
              cnt_q <= div_d;
              hold_full_q <= 1'b0;
            end else begin
              state_q <= IDLE;
              wait_q <= 1'b0;
            end
`else
            state_q <= IDLE;
            wait_q <= 1'b0;
`endif
          end
          default: ;
        endcase
      end
    end
  end
endmodule
